// File: rtl/count_mod_bcd.sv
// count_mod_bcd: modulo-MODULUS two-digit BCD counter (watch seconds/minutes/hours stage).
//
// The count is held directly as two BCD digit registers, so the outputs feed the 7-segment
// decoders with no conversion logic. Only one action is taken per cycle, in priority order
// load_i > dec_i (if built) > inc_i > tick_i. Only a tick-induced wrap pulses carry_o;
// adjust steps never ripple into the next stage.
//
// Optional feature: define ADJ_DEC_EN to add the dec_i (adjust -1) port.
//
// Parameters:
//   MODULUS    count range 0..MODULUS-1, legal 2..99
//   RST_VAL    binary reset value, must be < MODULUS
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   tick_i       count enable pulse (e.g. carry_o of the lower stage)
//   inc_i        adjust +1 pulse
//   dec_i        adjust -1 pulse (ADJ_DEC_EN only)
//   load_i       load request pulse
//   load_d1_i    BCD tens digit to load
//   load_d0_i    BCD units digit to load
//   segment0_o   BCD units digit (registered)
//   segment1_o   BCD tens digit (registered)
//   carry_o      1-cycle pulse, shown together with the wrapped 00 value
//   load_err_o   1-cycle pulse, load rejected

module count_mod_bcd #(
  parameter int unsigned MODULUS = 24,
  parameter int unsigned RST_VAL = 0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       tick_i,
  input  logic       inc_i,
`ifdef ADJ_DEC_EN
  input  logic       dec_i,
`endif
  input  logic       load_i,
  input  logic [3:0] load_d1_i,
  input  logic [3:0] load_d0_i,
  output logic [3:0] segment0_o,
  output logic [3:0] segment1_o,
  output logic       carry_o,
  output logic       load_err_o
);

  if (MODULUS < 2 || MODULUS > 99) begin : gen_bad_modulus
    $error("count_mod_bcd: MODULUS must be in 2..99");
  end
  if (RST_VAL >= MODULUS) begin : gen_bad_rst_val
    $error("count_mod_bcd: RST_VAL must be below MODULUS");
  end

  localparam logic [3:0] MaxD1 = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MaxD0 = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] RstD1 = 4'(RST_VAL / 10);
  localparam logic [3:0] RstD0 = 4'(RST_VAL % 10);
  localparam logic [7:0] ModVal = 8'(MODULUS);

  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic       carry_q, carry_d;
  logic       load_err_q, load_err_d;

  logic       dec_req;
  logic       at_max;
  logic       at_zero;
  logic [7:0] load_val;
  logic       load_ok;
  logic [3:0] up_d1, up_d0;
  logic [3:0] dn_d1, dn_d0;

`ifdef ADJ_DEC_EN
  assign dec_req = dec_i;
`else
  assign dec_req = 1'b0;
`endif

  assign at_max  = (d1_q == MaxD1) && (d0_q == MaxD0);
  assign at_zero = (d1_q == 4'd0) && (d0_q == 4'd0);

  // Max 15*10+15 = 165, fits in 8 bits; digit range is checked separately.
  assign load_val = 8'(load_d1_i) * 8'd10 + 8'(load_d0_i);
  assign load_ok  = (load_d1_i <= 4'd9) && (load_d0_i <= 4'd9) && (load_val < ModVal);

  // Increment by one with wrap at MODULUS-1.
  always_comb begin
    up_d1 = d1_q;
    up_d0 = d0_q;
    if (at_max) begin
      up_d1 = 4'd0;
      up_d0 = 4'd0;
    end else if (d0_q == 4'd9) begin
      up_d1 = d1_q + 4'd1;
      up_d0 = 4'd0;
    end else begin
      up_d0 = d0_q + 4'd1;
    end
  end

  // Decrement by one with wrap from 00 to MODULUS-1.
  always_comb begin
    dn_d1 = d1_q;
    dn_d0 = d0_q;
    if (at_zero) begin
      dn_d1 = MaxD1;
      dn_d0 = MaxD0;
    end else if (d0_q == 4'd0) begin
      dn_d1 = d1_q - 4'd1;
      dn_d0 = 4'd9;
    end else begin
      dn_d0 = d0_q - 4'd1;
    end
  end

  always_comb begin
    d1_d       = d1_q;
    d0_d       = d0_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      if (load_ok) begin
        d1_d = load_d1_i;
        d0_d = load_d0_i;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (dec_req) begin
      d1_d = dn_d1;
      d0_d = dn_d0;
    end else if (inc_i) begin
      d1_d = up_d1;
      d0_d = up_d0;
    end else if (tick_i) begin
      d1_d    = up_d1;
      d0_d    = up_d0;
      carry_d = at_max;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      d1_q       <= RstD1;
      d0_q       <= RstD0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      d1_q       <= d1_d;
      d0_q       <= d0_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign segment1_o = d1_q;
  assign segment0_o = d0_q;
  assign carry_o    = carry_q;
  assign load_err_o = load_err_q;

endmodule
